// File: rtl/bnn_infer_sequencer_if.sv
// UART-byte / XNOR-engine / UART-tx signal bundle seen by the BNN frame sequencer.
// The sequencer drives through master; the host/engine side connects to slave.
interface bnn_infer_sequencer_if #(
  parameter int VEC_W   = 64,
  parameter int CLS_W   = 3,
  parameter int SCORE_W = 7
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               rx_overrun;
  logic [VEC_W-1:0]   eng_vec;
  logic [CLS_W-1:0]   eng_class;
  logic               eng_start;
  logic               eng_done;
  logic [SCORE_W-1:0] eng_score;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;

  modport master (
    input  rx_data, rx_valid, eng_done, eng_score, tx_ready,
    output rx_ready, rx_overrun, eng_vec, eng_class, eng_start, tx_data, tx_valid, busy
  );

  modport slave (
    output rx_data, rx_valid, eng_done, eng_score, tx_ready,
    input  rx_ready, rx_overrun, eng_vec, eng_class, eng_start, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/bnn_infer_sequencer.sv
// Collects IN_BYTES into a vector, runs the engine once per class, returns {best class, best score}.
// All outputs registered: start 1 cycle after last byte/done; tx bytes hold until tx_ready.
module bnn_infer_sequencer #(
  parameter int IN_BYTES  = 8,
  parameter int N_CLASSES = 5,
  parameter int CLS_W     = 3,
  parameter int SCORE_W   = 7
) (
  input logic clk,
  input logic rst,
  bnn_infer_sequencer_if.master bus
);

  localparam int CNT_W = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND0 = 3'd3;
  localparam logic [2:0] S_SEND1 = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CLS_W-1:0]   best_cls;
  logic [CLS_W-1:0]   best_cls_nx;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] best_score_nx;
  logic               byte_acc;
  logic               last_byte;
  logic               last_class;
  logic               tx_fire;

  always_comb begin
    byte_acc      = (state == S_LOAD) && bus.rx_valid;
    last_byte     = (cnt == CNT_W'(IN_BYTES - 1));
    last_class    = (bus.eng_class == CLS_W'(N_CLASSES - 1));
    tx_fire       = bus.tx_valid && bus.tx_ready;
    state_nx      = state;
    best_cls_nx   = best_cls;
    best_score_nx = best_score;
    case (state)
      S_LOAD: begin
        if (byte_acc && last_byte) begin
          state_nx      = S_START;
          best_cls_nx   = '0;
          best_score_nx = '0;
        end
      end
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done) begin
          // Strict compare: on a tie the earlier (lower) class index wins.
          if (bus.eng_score > best_score) begin
            best_cls_nx   = bus.eng_class;
            best_score_nx = bus.eng_score;
          end
          state_nx = last_class ? S_SEND0 : S_START;
        end
      end
      S_SEND0: if (tx_fire) state_nx = S_SEND1;
      S_SEND1: if (tx_fire) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_LOAD;
      cnt            <= '0;
      best_cls       <= '0;
      best_score     <= '0;
      bus.eng_vec    <= '0;
      bus.eng_class  <= '0;
      bus.eng_start  <= 1'b0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= 8'h00;
      bus.rx_ready   <= 1'b1;
      bus.busy       <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      state      <= state_nx;
      best_cls   <= best_cls_nx;
      best_score <= best_score_nx;

      // Outputs are decoded from the next state so they are valid on entry.
      bus.rx_ready  <= (state_nx == S_LOAD);
      bus.busy      <= (state_nx != S_LOAD);
      bus.eng_start <= (state_nx == S_START);
      bus.tx_valid  <= (state_nx == S_SEND0) || (state_nx == S_SEND1);
      if (state_nx == S_SEND0)
        bus.tx_data <= 8'(best_cls_nx);
      else if (state_nx == S_SEND1)
        bus.tx_data <= 8'(best_score_nx);
      else
        bus.tx_data <= 8'h00;

      if (bus.rx_valid && !bus.rx_ready)
        bus.rx_overrun <= 1'b1;

      if (byte_acc) begin
        cnt <= last_byte ? '0 : cnt + CNT_W'(1);
        for (int k = 0; k < IN_BYTES; k++)
          if (cnt == CNT_W'(k))
            bus.eng_vec[8*k +: 8] <= bus.rx_data;
      end

      if (state == S_LOAD && state_nx == S_START)
        bus.eng_class <= '0;
      else if (state == S_WAIT && state_nx == S_START)
        bus.eng_class <= bus.eng_class + CLS_W'(1);
    end
  end

endmodule
